// File: rtl/memio_pkg.sv
// memio_pkg: shared types and constants for the Minisys data-access sequencer
package memio_pkg;
    typedef enum logic [2:0] {IDLE, RAM_ACC, IO_REQ, IO_WAIT, DONE} state_t;
    typedef enum logic [1:0] {MEM_RD, MEM_WR, IO_RD, IO_WR} kind_t;
    localparam logic [21:0] IO_BASE_HI = 22'h3FFFFF;
    localparam logic [31:0] DEF_TO_DATA = 32'hFFFF_FFFF;
    function automatic kind_t pick_kind(input logic mr, input logic mw, input logic ir, input logic iw);
        return iw ? IO_WR : ir ? IO_RD : mw ? MEM_WR : MEM_RD;
    endfunction
endpackage

// File: rtl/memio_if.sv
// memio_if: CPU request, RAM and I/O port signals of the data-access sequencer
interface memio_if;
    logic        mem_read, mem_write, io_read, io_write;
    logic [31:0] addr, wdata, ram_rdata, io_rdata;
    logic        io_ack, err_clr;
    logic        stall;
    logic [31:0] rdata;
    logic        ram_en, ram_we;
    logic [13:0] ram_addr;
    logic [31:0] ram_wdata;
    logic        io_rd_stb, io_wr_stb;
    logic [9:0]  io_addr;
    logic [31:0] io_wdata;
    logic        timeout_err, proto_err;
    modport master (
        output mem_read, mem_write, io_read, io_write, addr, wdata, ram_rdata, io_rdata, io_ack, err_clr,
        input  stall, rdata, ram_en, ram_we, ram_addr, ram_wdata, io_rd_stb, io_wr_stb, io_addr, io_wdata,
               timeout_err, proto_err
    );
    modport slave (
        input  mem_read, mem_write, io_read, io_write, addr, wdata, ram_rdata, io_rdata, io_ack, err_clr,
        output stall, rdata, ram_en, ram_we, ram_addr, ram_wdata, io_rd_stb, io_wr_stb, io_addr, io_wdata,
               timeout_err, proto_err
    );
endinterface

// File: rtl/memio_wait_cnt.sv
// memio_wait_cnt: 8-bit clear/enable wait counter with terminal-count compare
module memio_wait_cnt (
    input  logic       clock,
    input  logic       reset,
    input  logic       clr,
    input  logic       en,
    input  logic [7:0] term,
    output logic [7:0] cnt,
    output logic       tc
);
    always_ff @(posedge clock)
        if (reset || clr) cnt <= '0;
        else if (en) cnt <= cnt + 8'd1;
    assign tc = cnt == term;
endmodule

// File: rtl/memio_seq.sv
// memio_seq: multi-cycle sequencer for data RAM and memory-mapped I/O accesses,
// stalling the CPU until the access completes, aborts on I/O timeout.
module memio_seq
    import memio_pkg::*;
#(
    parameter int          RAM_LAT    = 1,
    parameter int          IO_TIMEOUT = 255,
    parameter logic [31:0] TO_DATA    = DEF_TO_DATA
) (
    input logic    clock,
    input logic    reset,
    memio_if.slave bus
);
    state_t      state, state_n;
    kind_t       kind, kind_in;
    logic        req, multi, tc, ack, to_set, waiting;
    logic [7:0]  cnt, term;
    logic [31:0] rdata_q, wdata_q;
    logic [13:0] ram_addr_q;
    logic [9:0]  io_addr_q;
    logic        timeout_q, proto_q, ram_en, ram_we, rd_stb, wr_stb;
    assign req     = bus.mem_read | bus.mem_write | bus.io_read | bus.io_write;
    assign multi   = $countones({bus.mem_read, bus.mem_write, bus.io_read, bus.io_write}) > 1;
    assign kind_in = pick_kind(bus.mem_read, bus.mem_write, bus.io_read, bus.io_write);
    assign ack     = bus.io_ack;
    assign waiting = state == RAM_ACC || state == IO_WAIT;
    assign term    = state == RAM_ACC ? 8'(RAM_LAT - 1) : 8'(IO_TIMEOUT - 1);
    assign to_set  = state == IO_WAIT && tc && !ack;
    memio_wait_cnt u_cnt (
        .clock(clock), .reset(reset), .clr(!waiting), .en(waiting), .term(term), .cnt(cnt), .tc(tc)
    );
    always_comb begin
        state_n = state;
        ram_en  = 1'b0;
        ram_we  = 1'b0;
        rd_stb  = 1'b0;
        wr_stb  = 1'b0;
        unique case (state)
            IDLE:    state_n = !req ? IDLE : (kind_in == IO_RD || kind_in == IO_WR) ? IO_REQ : RAM_ACC;
            RAM_ACC: begin
                ram_en  = cnt == 8'd0;
                ram_we  = cnt == 8'd0 && kind == MEM_WR;
                state_n = tc ? DONE : RAM_ACC;
            end
            IO_REQ:  begin
                rd_stb  = kind == IO_RD;
                wr_stb  = kind == IO_WR;
                state_n = ack ? DONE : IO_WAIT;
            end
            IO_WAIT: state_n = (ack || tc) ? DONE : IO_WAIT;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clock)
        if (reset) begin
            state      <= IDLE;
            kind       <= MEM_RD;
            rdata_q    <= '0;
            wdata_q    <= '0;
            ram_addr_q <= '0;
            io_addr_q  <= '0;
            timeout_q  <= 1'b0;
            proto_q    <= 1'b0;
        end else begin
            state <= state_n;
            if (state == IDLE && req) begin
                kind       <= kind_in;
                ram_addr_q <= bus.addr[15:2];
                io_addr_q  <= bus.addr[9:0];
                wdata_q    <= bus.wdata;
            end
            if (state == RAM_ACC && tc && kind == MEM_RD) rdata_q <= bus.ram_rdata;
            if ((state == IO_REQ || state == IO_WAIT) && kind == IO_RD)
                rdata_q <= ack ? bus.io_rdata : to_set ? TO_DATA : rdata_q;
            // a new error event in the same cycle as err_clr must survive
            timeout_q <= to_set | (timeout_q & ~bus.err_clr);
            proto_q   <= (state == IDLE && multi) | (proto_q & ~bus.err_clr);
        end
    assign bus.stall       = (state == IDLE && req) || state == RAM_ACC || state == IO_REQ || state == IO_WAIT;
    assign bus.rdata       = rdata_q;
    assign bus.ram_en      = ram_en;
    assign bus.ram_we      = ram_we;
    assign bus.ram_addr    = ram_addr_q;
    assign bus.ram_wdata   = wdata_q;
    assign bus.io_rd_stb   = rd_stb;
    assign bus.io_wr_stb   = wr_stb;
    assign bus.io_addr     = io_addr_q;
    assign bus.io_wdata    = wdata_q;
    assign bus.timeout_err = timeout_q;
    assign bus.proto_err   = proto_q;
endmodule

// File: tb/tb_memio_seq.sv
// tb_memio_seq: directed scoreboard bench for memio_seq (RAM_LAT=2, IO_TIMEOUT=4)
module tb_memio_seq;
    typedef struct {
        string       nm;
        logic [31:0] rdata;
        int          stall, en, we, stb;
    } exp_t;
    logic clk = 1'b0, rst = 1'b1, late_ack = 1'b0;
    int n_cmp = 0, n_bad = 0, ack_after = -1;
    exp_t sb[$];
    memio_if bus ();
    memio_seq #(.RAM_LAT(2), .IO_TIMEOUT(4)) dut (.clock(clk), .reset(rst), .bus(bus.slave));
    always #5 clk = ~clk;
    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask
    // peripheral model: acks ack_after cycles after its strobe, plus an optional stray ack
    initial begin
        bit pend = 0;
        int k = 0;
        bus.io_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.io_rd_stb || bus.io_wr_stb) begin pend = 1; k = 0; end
            else if (pend) k++;
            if (!bus.stall) pend = 0;
            bus.io_ack = (pend && k == ack_after) || late_ack;
            if (pend && k == ack_after) pend = 0;
        end
    end
    // monitor: counts activity over each stall window, compares when the CPU is released
    initial begin
        bit active = 0;
        int sc = 0, ec = 0, wc = 0, tc = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                active = 0; sc = 0; ec = 0; wc = 0; tc = 0;
            end else if (bus.stall) begin
                active = 1;
                sc++;
                ec += int'(bus.ram_en);
                wc += int'(bus.ram_we);
                tc += int'(bus.io_rd_stb || bus.io_wr_stb);
            end else if (active) begin
                if (sb.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_done: got completion expected none");
                end else begin
                    e = sb.pop_front();
                    check({e.nm, "_rdata"}, bus.rdata, e.rdata);
                    check({e.nm, "_stall"}, sc, e.stall);
                    check({e.nm, "_ram_en"}, ec, e.en);
                    check({e.nm, "_ram_we"}, wc, e.we);
                    check({e.nm, "_io_stb"}, tc, e.stb);
                end
                active = 0; sc = 0; ec = 0; wc = 0; tc = 0;
            end
        end
    end
    task automatic access(input logic [3:0] s, input logic [31:0] a, input logic [31:0] wd, input int ackd,
                          input exp_t e);
        int n = 0;
        sb.push_back(e);
        ack_after = ackd;
        {bus.mem_read, bus.mem_write, bus.io_read, bus.io_write} = s;
        bus.addr = a;
        bus.wdata = wd;
        @(posedge clk); #1;
        {bus.mem_read, bus.mem_write, bus.io_read, bus.io_write} = 4'b0;
        while (bus.stall && n < 400) begin @(posedge clk); #1; n++; end
        if (bus.stall) begin
            n_cmp++; n_bad++;
            $display("FAIL %s_hang: got stall=1 expected 0", e.nm);
        end
        @(posedge clk); #1;
    endtask
    task automatic pulse_clr();
        bus.err_clr = 1'b1;
        @(posedge clk); #1;
        bus.err_clr = 1'b0;
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
    initial begin
        {bus.mem_read, bus.mem_write, bus.io_read, bus.io_write} = 4'b0;
        bus.addr = '0; bus.wdata = '0; bus.err_clr = 1'b0;
        bus.ram_rdata = 32'h1234_5678; bus.io_rdata = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_stall", bus.stall, 0);
        check("rst_rdata", bus.rdata, 0);
        check("rst_ram_en", bus.ram_en, 0);
        check("rst_errs", {bus.timeout_err, bus.proto_err}, 0);
        access(4'b1000, 32'h0000_0010, 32'h0, -1, '{"ram_rd", 32'h1234_5678, 3, 1, 0, 0});
        check("ram_rd_addr", bus.ram_addr, 14'h004);
        access(4'b0100, 32'h0000_0020, 32'hDEAD_BEEF, -1, '{"ram_wr", 32'h1234_5678, 3, 1, 1, 0});
        check("ram_wr_addr", bus.ram_addr, 14'h008);
        check("ram_wr_wdata", bus.ram_wdata, 32'hDEAD_BEEF);
        bus.io_rdata = 32'h0000_00A5;
        access(4'b0010, 32'hFFFF_FC60, 32'h0, 3, '{"io_rd", 32'h0000_00A5, 5, 0, 0, 1});
        check("io_rd_addr", bus.io_addr, 10'h060);
        bus.io_rdata = 32'h0000_1111;
        access(4'b0010, 32'hFFFF_FC04, 32'h0, 0, '{"io_rd_fast", 32'h0000_1111, 2, 0, 0, 1});
        bus.io_rdata = 32'h0000_2222;
        access(4'b0010, 32'hFFFF_FC00, 32'h0, 4, '{"io_ack_wins", 32'h0000_2222, 6, 0, 0, 1});
        check("ack_wins_no_to", bus.timeout_err, 0);
        access(4'b0001, 32'hFFFF_FC10, 32'h0000_CAFE, -1, '{"io_wr_to", 32'h0000_2222, 6, 0, 0, 1});
        check("to_set", bus.timeout_err, 1);
        check("to_wdata", bus.io_wdata, 32'h0000_CAFE);
        @(posedge clk); #1;
        check("to_sticky", bus.timeout_err, 1);
        pulse_clr();
        check("to_clr", bus.timeout_err, 0);
        late_ack = 1'b1;
        @(posedge clk); #1;
        late_ack = 1'b0;
        @(posedge clk); #1;
        check("late_ack_stall", bus.stall, 0);
        check("late_ack_rdata", bus.rdata, 32'h0000_2222);
        check("late_ack_err", bus.timeout_err, 0);
        access(4'b0010, 32'hFFFF_FC20, 32'h0, -1, '{"io_rd_to", 32'hFFFF_FFFF, 6, 0, 0, 1});
        check("io_rd_to_err", bus.timeout_err, 1);
        pulse_clr();
        access(4'b1001, 32'hFFFF_FC08, 32'h0000_0055, 1, '{"proto", 32'hFFFF_FFFF, 3, 0, 0, 1});
        check("proto_err", bus.proto_err, 1);
        check("proto_io_addr", bus.io_addr, 10'h008);
        check("proto_to_err", bus.timeout_err, 0);
        pulse_clr();
        check("proto_clr", bus.proto_err, 0);
        ack_after = -1;
        bus.io_read = 1'b1; bus.addr = 32'hFFFF_FC30;
        @(posedge clk); #1;
        bus.io_read = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        check("pre_rst_stall", bus.stall, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid_rst_stall", bus.stall, 0);
        check("mid_rst_rdata", bus.rdata, 0);
        check("mid_rst_stb", {bus.io_rd_stb, bus.io_wr_stb, bus.ram_en}, 0);
        @(posedge clk); #1;
        check("post_rst_stall", bus.stall, 0);
        check("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/memio_seq.md
Name: memio_seq

Overview:
- Multi-cycle sequencer for the shared data-access resource in the Minisys datapath: data RAM plus the memory-mapped I/O port space (0xFFFFFC00–0xFFFFFFFF).
- Takes the decoder's MemRead/MemWrite/IORead/IOWrite strobes and the ALU address.
- Stalls the CPU while the access runs, drives RAM and I/O strobes, and returns load data.
- RAM accesses have a fixed latency. I/O accesses use an ack handshake with a timeout.

Parameters:
- RAM_LAT, 1, RAM read latency in cycles, legal range 1..15
- IO_TIMEOUT, 255, maximum cycles waiting for io_ack before abort, legal range 1..255
- TO_DATA, 32'hFFFF_FFFF, load data returned on an I/O timeout

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- mem_read  in  1  decoder MemRead
- mem_write  in  1  decoder MemWrite
- io_read  in  1  decoder IORead
- io_write  in  1  decoder IOWrite
- addr  in  32  ALU result (effective address)
- wdata  in  32  store data (rt value)
- ram_rdata  in  32  RAM read data
- io_rdata  in  32  I/O read data
- io_ack  in  1  peripheral completion
- err_clr  in  1  clears the sticky error flags
- stall  out  1  holds PC and IF/ID
- rdata  out  32  load result to writeback
- ram_en  out  1  RAM enable
- ram_we  out  1  RAM write enable
- ram_addr  out  14  latched addr[15:2]
- ram_wdata  out  32  latched store data
- io_rd_stb  out  1  I/O read strobe
- io_wr_stb  out  1  I/O write strobe
- io_addr  out  10  latched addr[9:0]
- io_wdata  out  32  latched store data
- timeout_err  out  1  sticky: an I/O access timed out
- proto_err  out  1  sticky: more than one request strobe was asserted together

Behaviour:
- Reset: state IDLE, all outputs 0, counters 0, rdata 0.
- States: IDLE, RAM_ACC, IO_REQ, IO_WAIT, DONE.
- req = mem_read | mem_write | io_read | io_write.
- stall (combinational) = (state==IDLE & req) | state ∈ {RAM_ACC, IO_REQ, IO_WAIT}. stall is 0 in DONE.
- IDLE, on edge with req:
  - latch addr and wdata, and record access kind.
  - Priority when several strobes are set: io_write > io_read > mem_write > mem_read.
  - If more than one strobe is set, proto_err is set.
  - Memory access goes to RAM_ACC with cnt=0; I/O access goes to IO_REQ.
- RAM_ACC:
  - ram_en=1 only while cnt==0; ram_we=1 in the same cycle for writes.
  - The state lasts exactly RAM_LAT cycles.
  - On the last cycle's edge, rdata is loaded from ram_rdata on reads. rdata is unchanged on writes.
  - Next state is DONE.
- IO_REQ:
  - One cycle; io_rd_stb or io_wr_stb = 1.
  - If io_ack=1 in this cycle, complete immediately: load io_rdata on reads, go to DONE.
  - Otherwise go to IO_WAIT with cnt=0.
- IO_WAIT:
  - Strobes are 0; cnt increments each cycle.
  - io_ack=1 completes as in IO_REQ.
  - If cnt reaches IO_TIMEOUT-1 with no ack: go to DONE, set rdata=TO_DATA on reads, set timeout_err.
  - If ack and timeout occur in the same cycle, ack wins.
- DONE:
  - One cycle with stall=0, so the CPU advances at this edge.
  - Request inputs are ignored.
  - Next state is IDLE.
- Latency, measured from the IDLE request cycle until stall drops: RAM = 1+RAM_LAT cycles; I/O = 2+N cycles, where N is the number of IO_WAIT cycles.
- Back-to-back accesses: the new request is seen in IDLE on the cycle after DONE.
- io_ack outside IO_REQ/IO_WAIT is ignored, including a late ack after a timeout.
- Sticky errors: cleared by err_clr at the edge. If a set and err_clr occur in the same cycle, set wins.
- Reset mid-operation: returns to IDLE at that edge, strobes drop, and the partial access is abandoned with no rdata update.
- ram_addr/io_addr/ram_wdata/io_wdata stay stable from latch until the next request is latched.

Decomposition:
- Package memio_pkg: state enum (3-bit), access-kind enum (MEM_RD, MEM_WR, IO_RD, IO_WR), IO_BASE_HI = 22'h3FFFFF, default TO_DATA.
- One sub-module is natural: memio_wait_cnt, an 8-bit clear/enable counter with a terminal-count compare. It is shared by RAM_ACC and IO_WAIT.

Test Plan:
- RAM_LAT=2, mem_read at addr 0x00000010, ram_rdata=0x12345678 → ram_en for 1 cycle with ram_addr=0x004; stall high 3 cycles; rdata=0x12345678 in DONE.
- mem_write at addr 0x20, wdata=0xDEADBEEF → ram_en=ram_we=1 for one cycle; ram_wdata=0xDEADBEEF; stall high 1+RAM_LAT cycles.
- io_read at addr 0xFFFFFC60, io_ack 3 cycles after io_rd_stb, io_rdata=0x00A5 → io_addr=0x060; single-cycle strobe; rdata=0x000000A5; stall drops 5 cycles after the request cycle.
- io_write with io_ack never asserted, IO_TIMEOUT=4 → DONE after 4 IO_WAIT cycles; timeout_err=1 and stays 1; err_clr pulse → 0; a later ack is ignored.
- mem_read and io_write asserted together → I/O write performed; proto_err=1.
- reset asserted in IO_WAIT → next cycle state IDLE, stall=0 (no request), rdata unchanged from 0, strobes 0.
